nibble_bus_arbiter: RTL and testbench

Shares the single external nibble memory bus (address on `uo_out`/`uio[7:6]`, cycle tag on `uio[5:4]`, data on `uio[3:0]`) between two requesters: the CPU core (requester C) and the host/debug loader (requester H).
- Arbitrates between C and H and sequences each granted access onto the pads.
- Inserts a bus turnaround cycle whenever a write is followed by a read.
- Returns read data and a completion strobe to the owning requester.
- Sits between the core and the top-level pad assignments.

---
 rtl/nibble_bus_arbiter_if.sv | 42 ++++
 rtl/nibble_bus_arbiter.sv | 107 ++++++++++
 tb/tb_nibble_bus_arbiter.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_bus_arbiter_if.sv
// Connections between the nibble-bus arbiter, its two requesters (C and H) and the pad ring.
// The arbiter takes the slave modport. The requester and pad side takes the master modport.
interface nibble_bus_arbiter_if;
    logic       c_req;
    logic       c_we;
    logic [9:0] c_addr;
    logic [1:0] c_kind;
    logic [3:0] c_wdata;
    logic       c_ack;
    logic [3:0] c_rdata;

    logic       h_req;
    logic       h_we;
    logic [9:0] h_addr;
    logic [1:0] h_kind;
    logic [3:0] h_wdata;
    logic       h_ack;
    logic [3:0] h_rdata;

    logic [7:0] bus_out;
    logic [7:0] bus_uio_out;
    logic [7:0] bus_uio_oe;
    logic [3:0] bus_uio_in;

    modport slave (
        input  c_req, c_we, c_addr, c_kind, c_wdata,
        output c_ack, c_rdata,
        input  h_req, h_we, h_addr, h_kind, h_wdata,
        output h_ack, h_rdata,
        output bus_out, bus_uio_out, bus_uio_oe,
        input  bus_uio_in
    );

    modport master (
        output c_req, c_we, c_addr, c_kind, c_wdata,
        input  c_ack, c_rdata,
        output h_req, h_we, h_addr, h_kind, h_wdata,
        input  h_ack, h_rdata,
        input  bus_out, bus_uio_out, bus_uio_oe,
        output bus_uio_in
    );
endinterface

// File: rtl/nibble_bus_arbiter.sv
// Arbitrates the external nibble bus between the CPU core (C) and the host loader (H).
// It bounds how long H waits under C traffic, and it inserts one turnaround cycle when a write is followed by a read.
module nibble_bus_arbiter #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    nibble_bus_arbiter_if.slave bus
);
    localparam logic [2:0] HOLD_LIM = 3'(HOLD_MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        TURN   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_C = 1'b0,
        OWN_H = 1'b1
    } owner_e;

    state_e     state_q, state_d;
    owner_e     owner_q, owner_d;
    logic       last_we_q, last_we_d;
    logic [2:0] streak_q, streak_d;

    logic       hold_hit;
    logic       win_c;
    logic       win_h;
    logic       win_we;
    logic [2:0] streak_upd;

    // H gets priority only after C has been granted HOLD_MAX times in a row while H was waiting.
    always_comb begin
        hold_hit = bus.h_req && (streak_q == HOLD_LIM);
        win_c    = bus.c_req && !hold_hit;
        win_h    = bus.h_req && !win_c;
        win_we   = win_c ? bus.c_we : bus.h_we;
        if (win_c && bus.h_req) begin
            streak_upd = (streak_q >= HOLD_LIM) ? HOLD_LIM : streak_q + 3'd1;
        end else begin
            streak_upd = 3'd0;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_we_d = last_we_q;
        streak_d  = streak_q;
        case (state_q)
            IDLE, ACCESS: begin
                streak_d = streak_upd;
                if (win_c || win_h) begin
                    owner_d   = win_c ? OWN_C : OWN_H;
                    last_we_d = win_we;
                    // last_we_q holds the direction of the access that is on the bus now.
                    state_d   = (state_q == ACCESS && last_we_q && !win_we) ? TURN : ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            TURN:    state_d = ACCESS;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_C;
            last_we_q <= 1'b0;
            streak_q  <= 3'd0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_we_q <= last_we_d;
            streak_q  <= streak_d;
        end
    end

    logic       in_access;
    logic       sel_h;
    logic       cur_we;
    logic [9:0] cur_addr;
    logic [1:0] cur_kind;
    logic [3:0] cur_wdata;

    always_comb begin
        in_access = (state_q == ACCESS);
        sel_h     = (owner_q == OWN_H);
        cur_we    = sel_h ? bus.h_we    : bus.c_we;
        cur_addr  = sel_h ? bus.h_addr  : bus.c_addr;
        cur_kind  = sel_h ? bus.h_kind  : bus.c_kind;
        cur_wdata = sel_h ? bus.h_wdata : bus.c_wdata;
    end

    // Every output decodes the registered state, so an asynchronous reset clears the pads immediately.
    assign bus.c_ack       = in_access && !sel_h;
    assign bus.h_ack       = in_access && sel_h;
    assign bus.c_rdata     = bus.c_ack ? bus.bus_uio_in : 4'h0;
    assign bus.h_rdata     = bus.h_ack ? bus.bus_uio_in : 4'h0;
    assign bus.bus_out     = in_access ? cur_addr[9:2] : 8'h00;
    assign bus.bus_uio_out = in_access ? {cur_addr[1:0], cur_kind, (cur_we ? cur_wdata : 4'h0)} : 8'h00;
    assign bus.bus_uio_oe  = (in_access && cur_we) ? 8'hFF : 8'hF0;
endmodule

// File: tb/tb_nibble_bus_arbiter.sv
// Bench for nibble_bus_arbiter: directed vector table, hand-written multi-cycle sequences,
// and randomized requester traffic checked against a grant-schedule model.
module tb_nibble_bus_arbiter;
    localparam int HOLD_MAX = 4;

    typedef struct packed {
        logic       req;
        logic       we;
        logic [9:0] addr;
        logic [1:0] kind;
        logic [3:0] wdata;
    } req_t;

    typedef struct packed {
        logic        rst;
        req_t        c;
        req_t        h;
        logic [3:0]  uio_in;
        logic [33:0] exp;
    } vec_t;

    localparam logic [33:0] IDLE_EXP = {1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00, 8'hF0};
    localparam req_t NOREQ = '0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    nibble_bus_arbiter_if bus_if ();

    nibble_bus_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model of the bus schedule: 0 idle, 1 C on bus, 2 H on bus, 3 turnaround before m_turn_for.
    int m_hold     = 0;
    int m_turn_for = 0;
    int m_run      = 0;

    function automatic req_t rq(logic r, logic w, logic [9:0] a, logic [1:0] k, logic [3:0] d);
        return '{req: r, we: w, addr: a, kind: k, wdata: d};
    endfunction

    function automatic logic [33:0] ex(logic ca, logic ha, logic [3:0] cr, logic [3:0] hr,
                                       logic [7:0] bo, logic [7:0] uo, logic [7:0] oe);
        return {ca, ha, cr, hr, bo, uo, oe};
    endfunction

    function automatic logic [33:0] snap();
        return {bus_if.c_ack, bus_if.h_ack, bus_if.c_rdata, bus_if.h_rdata,
                bus_if.bus_out, bus_if.bus_uio_out, bus_if.bus_uio_oe};
    endfunction

    task automatic drive(input logic r, input req_t c, input req_t h, input logic [3:0] u);
        rst            = r;
        bus_if.c_req   = c.req;   bus_if.c_we   = c.we;   bus_if.c_addr = c.addr;
        bus_if.c_kind  = c.kind;  bus_if.c_wdata = c.wdata;
        bus_if.h_req   = h.req;   bus_if.h_we   = h.we;   bus_if.h_addr = h.addr;
        bus_if.h_kind  = h.kind;  bus_if.h_wdata = h.wdata;
        bus_if.bus_uio_in = u;
    endtask

    task automatic check(input string name, input logic [33:0] exp);
        logic [33:0] act;
        act = snap();
        n_checks++;
        if (act === exp) begin
            n_pass++;
            $display("%-16s ok   outputs=%h", name, act);
        end else begin
            $display("FAIL %-16s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [33:0] model_expect();
        logic       we;
        logic [9:0] a;
        logic [1:0] k;
        logic [3:0] d;
        logic [3:0] u;
        u = bus_if.bus_uio_in;
        if (m_hold != 1 && m_hold != 2) return IDLE_EXP;
        we = (m_hold == 1) ? bus_if.c_we    : bus_if.h_we;
        a  = (m_hold == 1) ? bus_if.c_addr  : bus_if.h_addr;
        k  = (m_hold == 1) ? bus_if.c_kind  : bus_if.h_kind;
        d  = (m_hold == 1) ? bus_if.c_wdata : bus_if.h_wdata;
        return ex(m_hold == 1, m_hold == 2, (m_hold == 1) ? u : 4'h0, (m_hold == 2) ? u : 4'h0,
                  a[9:2], {a[1:0], k, (we ? d : 4'h0)}, we ? 8'hFF : 8'hF0);
    endfunction

    // Decide who owns the next cycle from the requests visible at this clock edge.
    task automatic model_step();
        int pick;
        bit cur_wr;
        bit pick_we;
        if (m_hold == 3) begin
            m_hold = m_turn_for;
        end else begin
            cur_wr = (m_hold == 1 && bus_if.c_we) || (m_hold == 2 && bus_if.h_we);
            if (bus_if.h_req && m_run >= HOLD_MAX) pick = 2;
            else if (bus_if.c_req)                 pick = 1;
            else if (bus_if.h_req)                 pick = 2;
            else                                   pick = 0;
            m_run = (pick == 1 && bus_if.h_req) ? ((m_run + 1 > HOLD_MAX) ? HOLD_MAX : m_run + 1) : 0;
            pick_we = (pick == 1) ? bus_if.c_we : bus_if.h_we;
            if (pick == 0) begin
                m_hold = 0;
            end else if (cur_wr && !pick_we) begin
                m_hold     = 3;
                m_turn_for = pick;
            end else begin
                m_hold = pick;
            end
        end
    endtask

    vec_t vecs [15];

    initial begin
        string pat;
        logic [33:0] e;

        vecs[0]  = '{1'b1, rq(1, 0, 10'h2A5, 2'd1, 4'h0), rq(1, 0, 10'h155, 2'd2, 4'h0), 4'h9, IDLE_EXP};
        vecs[1]  = '{1'b0, NOREQ, NOREQ, 4'h0, IDLE_EXP};
        vecs[2]  = '{1'b0, NOREQ, NOREQ, 4'h0, IDLE_EXP};
        vecs[3]  = '{1'b0, rq(1, 0, 10'h2A5, 2'd1, 4'h0), NOREQ, 4'h9, IDLE_EXP};
        vecs[4]  = '{1'b0, rq(0, 0, 10'h2A5, 2'd1, 4'h0), NOREQ, 4'h9, ex(1, 0, 4'h9, 4'h0, 8'hA9, 8'h50, 8'hF0)};
        vecs[5]  = '{1'b0, NOREQ, NOREQ, 4'h0, IDLE_EXP};
        vecs[6]  = '{1'b0, rq(1, 1, 10'h003, 2'd3, 4'hA), rq(1, 0, 10'h155, 2'd2, 4'h0), 4'h5, IDLE_EXP};
        vecs[7]  = '{1'b0, rq(0, 1, 10'h003, 2'd3, 4'hA), rq(1, 0, 10'h155, 2'd2, 4'h0), 4'h5, ex(1, 0, 4'h5, 4'h0, 8'h00, 8'hFA, 8'hFF)};
        vecs[8]  = '{1'b0, NOREQ, rq(1, 0, 10'h155, 2'd2, 4'h0), 4'h6, IDLE_EXP};
        vecs[9]  = '{1'b0, NOREQ, rq(0, 0, 10'h155, 2'd2, 4'h0), 4'h6, ex(0, 1, 4'h0, 4'h6, 8'h55, 8'h60, 8'hF0)};
        vecs[10] = '{1'b0, NOREQ, NOREQ, 4'h0, IDLE_EXP};
        vecs[11] = '{1'b0, rq(1, 0, 10'h3FF, 2'd0, 4'h0), rq(1, 0, 10'h000, 2'd3, 4'h0), 4'h3, IDLE_EXP};
        vecs[12] = '{1'b0, rq(0, 0, 10'h3FF, 2'd0, 4'h0), rq(1, 0, 10'h000, 2'd3, 4'h0), 4'h3, ex(1, 0, 4'h3, 4'h0, 8'hFF, 8'hC0, 8'hF0)};
        vecs[13] = '{1'b0, NOREQ, rq(0, 0, 10'h000, 2'd3, 4'h0), 4'h3, ex(0, 1, 4'h0, 4'h3, 8'h00, 8'h30, 8'hF0)};
        vecs[14] = '{1'b0, NOREQ, NOREQ, 4'h0, IDLE_EXP};

        drive(1'b0, NOREQ, NOREQ, 4'h0);
        #2;
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rst, vecs[i].c, vecs[i].h, vecs[i].uio_in);
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp);
            step();
        end

        // C write immediately followed by a C read: the read must wait one turnaround cycle.
        drive(1'b0, rq(1, 1, 10'h003, 2'd3, 4'hA), NOREQ, 4'h0);
        #1; check("wr_rd_idle", IDLE_EXP);
        step(); #1;
        check("wr_rd_write", ex(1, 0, 4'h0, 4'h0, 8'h00, 8'hFA, 8'hFF));
        drive(1'b0, rq(1, 0, 10'h010, 2'd0, 4'h0), NOREQ, 4'h0);
        step(); #1;
        check("wr_rd_turn", IDLE_EXP);
        step();
        drive(1'b0, rq(0, 0, 10'h010, 2'd0, 4'h0), NOREQ, 4'hC);
        #1; check("wr_rd_read", ex(1, 0, 4'hC, 4'h0, 8'h04, 8'h00, 8'hF0));
        step(); #1;
        check("wr_rd_done", IDLE_EXP);

        // Both requesters hold continuous reads: HOLD_MAX C grants, then one H grant.
        pat = "CCCCHCCCCH";
        drive(1'b0, rq(1, 0, 10'h2A5, 2'd1, 4'h0), rq(1, 0, 10'h155, 2'd2, 4'h0), 4'h4);
        #1; check("fair_idle", IDLE_EXP);
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 9) bus_if.h_req = 1'b0;
            #1;
            e = (pat[i] == "C") ? ex(1, 0, 4'h4, 4'h0, 8'hA9, 8'h50, 8'hF0)
                                : ex(0, 1, 4'h0, 4'h4, 8'h55, 8'h60, 8'hF0);
            check($sformatf("fair%0d_%s", i, pat.substr(i, i)), e);
        end
        step();
        bus_if.c_req = 1'b0;
        #1; check("fair_tail_c", ex(1, 0, 4'h4, 4'h0, 8'hA9, 8'h50, 8'hF0));
        step(); #1;
        check("fair_done", IDLE_EXP);

        // Reset lands in the middle of an H write. The pads must release before any clock edge.
        drive(1'b0, NOREQ, rq(1, 1, 10'h0F0, 2'd1, 4'h7), 4'h2);
        #1; check("mrst_idle", IDLE_EXP);
        step(); #1;
        check("mrst_hwrite", ex(0, 1, 4'h0, 4'h2, 8'h3C, 8'h17, 8'hFF));
        drive(1'b1, rq(1, 0, 10'h2A5, 2'd1, 4'h0), rq(1, 1, 10'h0F0, 2'd1, 4'h7), 4'h2);
        #1; check("mrst_async", IDLE_EXP);
        step(); #1;
        check("mrst_held", IDLE_EXP);
        drive(1'b0, rq(1, 0, 10'h2A5, 2'd1, 4'h0), NOREQ, 4'h2);
        #1; check("mrst_release", IDLE_EXP);
        step();
        drive(1'b0, rq(0, 0, 10'h2A5, 2'd1, 4'h0), NOREQ, 4'h9);
        #1; check("mrst_c_first", ex(1, 0, 4'h9, 4'h0, 8'hA9, 8'h50, 8'hF0));
        step(); #1;
        check("mrst_done", IDLE_EXP);

        // Randomized traffic. Each requester holds its fields until it is acked.
        m_hold = 0;
        m_run  = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!bus_if.c_req) begin
                if ($urandom_range(2) == 0) begin
                    bus_if.c_req   = 1'b1;
                    bus_if.c_we    = 1'($urandom_range(1));
                    bus_if.c_addr  = 10'($urandom);
                    bus_if.c_kind  = 2'($urandom);
                    bus_if.c_wdata = 4'($urandom);
                end
            end else if (m_hold == 1 && $urandom_range(3) == 0) begin
                bus_if.c_req = 1'b0;
            end
            if (!bus_if.h_req) begin
                if ($urandom_range(2) == 0) begin
                    bus_if.h_req   = 1'b1;
                    bus_if.h_we    = 1'($urandom_range(1));
                    bus_if.h_addr  = 10'($urandom);
                    bus_if.h_kind  = 2'($urandom);
                    bus_if.h_wdata = 4'($urandom);
                end
            end else if (m_hold == 2 && $urandom_range(1) == 0) begin
                bus_if.h_req = 1'b0;
            end
            bus_if.bus_uio_in = 4'($urandom);
            #1;
            check($sformatf("rand%0d", cyc), model_expect());
            model_step();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
